// File: rtl/multi_lane_fifo.sv
// Multi-lane FIFO: NUM_LANES independent write streams joined per index onto one valid/ready output.
// Optional sticky overflow flag enabled by defining MULTI_LANE_FIFO_OVERFLOW_EN.
module multi_lane_fifo #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            flush_in,
    input  logic [NUM_LANES-1:0]            lane_valid_in,
    output logic [NUM_LANES-1:0]            lane_ready_out,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_data_in,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [NUM_LANES*LANE_WIDTH-1:0] data_out,
    output logic [$clog2(DEPTH):0]          count_out
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
    ,
    output logic                            overflow_out
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = NUM_LANES * LANE_WIDTH;

    logic [NUM_LANES-1:0][PW-1:0] wr_q, occ;
    logic [NUM_LANES-1:0]         wr_en;
    logic [PW-1:0]                cons_q, rd_q, inflight, min_occ;
    logic                         rd_en, rd_vld_q, xfer, head_q;
    logic [1:0]                   buf_cnt_q;
    logic [DW-1:0]                rd_data;
    logic [1:0][DW-1:0]           buf_q;

    always_comb begin
        min_occ = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
            occ[i]            = wr_q[i] - cons_q;
            lane_ready_out[i] = (occ[i] != PW'(DEPTH)) && !flush_in && rst_n_in;
            wr_en[i]          = lane_valid_in[i] && lane_ready_out[i];
            if (occ[i] < min_occ) min_occ = occ[i];
        end
    end

    assign count_out = min_occ;
    assign valid_out = (buf_cnt_q != 2'd0);
    assign data_out  = buf_q[head_q];
    assign xfer      = valid_out && ready_in && !flush_in;
    // inflight covers the RAM output register plus the skid slots; a consume this
    // cycle frees a slot early so a steady stream runs without bubbles.
    assign inflight  = rd_q - cons_q;
    assign rd_en     = !flush_in && (min_occ > inflight) && ((inflight - PW'(xfer)) < PW'(2));

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];
        logic [LANE_WIDTH-1:0] rd_word_q;

        always_ff @(posedge clk_in) begin
            if (wr_en[g]) mem[wr_q[g][AW-1:0]] <= lane_data_in[g*LANE_WIDTH +: LANE_WIDTH];
            if (rd_en)    rd_word_q <= mem[rd_q[AW-1:0]];
        end

        assign rd_data[g*LANE_WIDTH +: LANE_WIDTH] = rd_word_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_q      <= '0;
            cons_q    <= '0;
            rd_q      <= '0;
            rd_vld_q  <= 1'b0;
            buf_q     <= '0;
            buf_cnt_q <= 2'd0;
            head_q    <= 1'b0;
        end else if (flush_in) begin
            wr_q      <= '0;
            cons_q    <= '0;
            rd_q      <= '0;
            rd_vld_q  <= 1'b0;
            buf_cnt_q <= 2'd0;
            head_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) wr_q[i] <= wr_q[i] + PW'(wr_en[i]);
            if (xfer)  cons_q <= cons_q + PW'(1);
            if (rd_en) rd_q   <= rd_q + PW'(1);
            rd_vld_q <= rd_en;
            // Slot budget guarantees the buffer is never full when a fetched word lands.
            if (rd_vld_q) buf_q[head_q ^ buf_cnt_q[0]] <= rd_data;
            if (xfer) head_q <= ~head_q;
            buf_cnt_q <= buf_cnt_q + 2'(rd_vld_q) - 2'(xfer);
        end
    end

`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                                  ovf_q <= 1'b0;
        else if (flush_in)                              ovf_q <= 1'b0;
        else if (|(lane_valid_in & ~lane_ready_out))    ovf_q <= 1'b1;
    end

    assign overflow_out = ovf_q;
`endif
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Randomized + directed bench for multi_lane_fifo (2 lanes x 8 bits x depth 4)
// checked against per-lane word queues.
module tb_multi_lane_fifo;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [1:0]  lane_valid_in = '0;
    logic [1:0]  lane_ready_out;
    logic [15:0] lane_data_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [15:0] data_out;
    logic [2:0]  count_out;
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
    logic        overflow_out;
`endif

    multi_lane_fifo #(.NUM_LANES(2), .LANE_WIDTH(8), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
        .lane_valid_in(lane_valid_in), .lane_ready_out(lane_ready_out),
        .lane_data_in(lane_data_in), .valid_out(valid_out), .ready_in(ready_in),
        .data_out(data_out), .count_out(count_out)
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
        , .overflow_out(overflow_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_out = 0, first_x = -1, last_x = -1;
    logic [7:0] lq0[$], lq1[$];
    logic m_ovf = 1'b0;
    logic hold = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mcount();
        return (lq0.size() < lq1.size()) ? lq0.size() : lq1.size();
    endfunction

    function automatic void mclear();
        lq0.delete();
        lq1.delete();
        hold = 1'b0;
    endfunction

    // One clock: entered at a negedge with inputs already driven.
    task automatic cycle();
        logic [1:0] er;
        logic x;
        #1;
        er = {lq1.size() != 4, lq0.size() != 4} & {2{!flush_in}};
        chk("ready", 32'(lane_ready_out), 32'(er));
        chk("count", 32'(count_out), 32'(mcount()));
        chk("vld_no_entry", 32'(valid_out && mcount() == 0), 32'd0);
        if (valid_out && mcount() > 0) chk("data", 32'(data_out), {16'd0, lq1[0], lq0[0]});
        if (hold) begin
            chk("hold_vld", 32'(valid_out), 32'd1);
            chk("hold_data", 32'(data_out), 32'(prev_data));
        end
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
        chk("ovf", 32'(overflow_out), 32'(m_ovf));
`endif
        hold      = valid_out && !ready_in && !flush_in;
        prev_data = data_out;
        x         = valid_out && ready_in && !flush_in;
        @(posedge clk_in);
        if (flush_in) begin
            mclear();
            m_ovf = 1'b0;
        end else begin
            if (x && mcount() > 0) begin
                void'(lq0.pop_front());
                void'(lq1.pop_front());
                n_out++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            if (lane_valid_in[0] && er[0]) lq0.push_back(lane_data_in[7:0]);
            if (lane_valid_in[1] && er[1]) lq1.push_back(lane_data_in[15:8]);
            if (|(lane_valid_in & ~er)) m_ovf = 1'b1;
        end
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                         input logic r, input logic f);
        lane_valid_in = v;
        lane_data_in  = {d1, d0};
        ready_in      = r;
        flush_in      = f;
    endtask

    task automatic drain(input int budget);
        drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < budget && mcount() > 0; i++) cycle();
        chk("drained", 32'(mcount()), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_vld", 32'(valid_out), 32'd0);
        chk("rst_cnt", 32'(count_out), 32'd0);
        chk("rst_rdy", 32'(lane_ready_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 chk("rel_rdy", 32'(lane_ready_out), 32'd3);

        // Lane 1 lags: nothing until its word lands, then exactly two edges later.
        drive(2'b01, 8'h00, 8'h11, 1'b0, 1'b0); cycle();
        drive(2'b01, 8'h00, 8'h22, 1'b0, 1'b0); cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) cycle();
        drive(2'b10, 8'hA1, 8'h00, 1'b0, 1'b0); cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        #1 chk("lat_e1", 32'(valid_out), 32'd0);
        chk("lat_cnt", 32'(count_out), 32'd1);
        cycle();
        #1 chk("lat_e2", 32'(valid_out), 32'd0);
        cycle();
        #1 chk("lat_e3", 32'(valid_out), 32'd1);
        chk("lat_data", 32'(data_out), 32'h0000A111);
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1); cycle();

        // Fill to full with ready low, then a dropped lane-0 write.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 8'(8'h40 + i), 8'(8'h30 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) cycle();
        #1 chk("full_rdy", 32'(lane_ready_out), 32'd0);
        chk("full_cnt", 32'(count_out), 32'd4);
        drive(2'b01, 8'h00, 8'hEE, 1'b0, 1'b0); cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0); cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        #1 chk("unfull_rdy", 32'(lane_ready_out), 32'd3);
        cycle();

        // Flush with 3 queued, a concurrent write and a concurrent consume.
        drive(2'b11, 8'h77, 8'h66, 1'b1, 1'b1); cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        #1 chk("flush_cnt", 32'(count_out), 32'd0);
        chk("flush_vld", 32'(valid_out), 32'd0);
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
        chk("flush_ovf", 32'(overflow_out), 32'd0);
`endif
        cycle();

        // Streaming 12 words: pointers wrap three times, one entry per cycle.
        first_x = -1;
        n_out = 0;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, 8'(i), 8'(i), 1'b1, 1'b0);
            cycle();
        end
        drain(20);
        chk("stream_n", 32'(n_out), 32'd12);
        chk("stream_gap", 32'(last_x - first_x), 32'd11);

        // Random valids, data, ready and rare flushes.
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
            cycle();
        end
        drain(20);

        // Asynchronous reset between edges, mid-stream.
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            cycle();
        end
        @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_vld", 32'(valid_out), 32'd0);
        chk("arst_cnt", 32'(count_out), 32'd0);
        chk("arst_rdy", 32'(lane_ready_out), 32'd0);
        chk("arst_data", 32'(data_out), 32'd0);
`ifdef MULTI_LANE_FIFO_OVERFLOW_EN
        chk("arst_ovf", 32'(overflow_out), 32'd0);
`endif
        mclear();
        m_ovf = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) cycle();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            cycle();
        end
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
